// File: rtl/csa_resolver.sv
// csa_resolver: resolves a carry-save pair (p, q) into a binary result r.
// Both words are added slice by slice, W bits per cycle, and the carry out
// of bit N is dropped. The optional reduction subtracts the modulus n
// repeatedly, up to four passes, until the subtraction borrows.
// Build option: define CSA_RESOLVER_REDUCE_EN to include the reduction
// passes (SUB state, diff register). Without it, r = (p+q) mod 2^(N+1),
// err stays 0 and n is unused.
module csa_resolver #(
    parameter int N = 1024,
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic [N:0]   p,
    input  logic [N:0]   q,
    input  logic [N-1:0] n,
    output logic         busy,
    output logic         done,
    output logic [N:0]   r,
    output logic         err
);
    localparam int K  = (N + W) / W;
    localparam int PW = K * W;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);
    localparam logic [PW-1:0] MASK = PW'({(N+1){1'b1}});

    typedef enum logic [1:0] {IDLE, ADD, SUB, FIN} stateT;

    stateT         state;
    stateT         nextState;
    logic [PW-1:0] pReg;
    logic [PW-1:0] qReg;
    logic [PW-1:0] sumReg;
    logic [PW-1:0] sumNext;
    logic [CW-1:0] sliceIdx;
    logic          carry;
    logic [W:0]    addSlice;
    logic          lastSlice;
    int            base;

`ifdef CSA_RESOLVER_REDUCE_EN
    logic [PW-1:0] nReg;
    logic [PW-1:0] diffReg;
    logic [PW-1:0] diffNext;
    logic [W:0]    subSlice;
    logic          borrow;
    logic [1:0]    passCnt;
`else
    logic          unusedN;
    assign unusedN = ^n;
    assign err     = 1'b0;
`endif

    assign lastSlice = (sliceIdx == LAST);

    // Slice adder: current slice of p + q + carry, merged into the sum word
    // with everything above bit N cleared so the top carry never survives.
    always_comb begin
        base     = int'(sliceIdx) * W;
        addSlice = {1'b0, pReg[base +: W]} + {1'b0, qReg[base +: W]} + (W+1)'(carry);
        sumNext  = sumReg;
        sumNext[base +: W] = addSlice[W-1:0];
        sumNext  = sumNext & MASK;
    end

`ifdef CSA_RESOLVER_REDUCE_EN
    // Slice subtractor: sum - n with borrow; bit W of the result is the borrow out.
    always_comb begin
        subSlice = {1'b0, sumReg[base +: W]} - {1'b0, nReg[base +: W]} - (W+1)'(borrow);
        diffNext = diffReg;
        diffNext[base +: W] = subSlice[W-1:0];
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: ADD and each SUB pass run for exactly K slices.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (start) nextState = ADD;
`ifdef CSA_RESOLVER_REDUCE_EN
            ADD:  if (lastSlice) nextState = SUB;
            SUB:  if (lastSlice && (subSlice[W] || passCnt == 2'd3)) nextState = FIN;
`else
            ADD:  if (lastSlice) nextState = FIN;
`endif
            FIN:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = (state != IDLE);
        done = (state == FIN);
    end

    // Datapath: operand capture, slice-serial add/subtract, result update.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pReg     <= '0;
            qReg     <= '0;
            sumReg   <= '0;
            carry    <= 1'b0;
            sliceIdx <= '0;
            r        <= '0;
`ifdef CSA_RESOLVER_REDUCE_EN
            nReg     <= '0;
            diffReg  <= '0;
            borrow   <= 1'b0;
            passCnt  <= '0;
            err      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pReg     <= PW'(p);
                        qReg     <= PW'(q);
                        carry    <= 1'b0;
                        sliceIdx <= '0;
`ifdef CSA_RESOLVER_REDUCE_EN
                        nReg     <= PW'(n);
                        borrow   <= 1'b0;
                        passCnt  <= '0;
`endif
                    end
                end
                ADD: begin
                    sumReg <= sumNext;
                    carry  <= addSlice[W];
                    if (lastSlice) begin
                        sliceIdx <= '0;
`ifndef CSA_RESOLVER_REDUCE_EN
                        r <= sumNext[N:0];
`endif
                    end else begin
                        sliceIdx <= sliceIdx + CW'(1);
                    end
                end
`ifdef CSA_RESOLVER_REDUCE_EN
                SUB: begin
                    diffReg <= diffNext;
                    borrow  <= subSlice[W];
                    if (lastSlice) begin
                        sliceIdx <= '0;
                        borrow   <= 1'b0;
                        if (subSlice[W]) begin
                            r   <= sumReg[N:0];
                            err <= 1'b0;
                        end else begin
                            sumReg <= diffNext;
                            if (passCnt == 2'd3) begin
                                r   <= diffNext[N:0];
                                err <= 1'b1;
                            end else begin
                                passCnt <= passCnt + 2'd1;
                            end
                        end
                    end else begin
                        sliceIdx <= sliceIdx + CW'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_csa_resolver.sv
// tb_csa_resolver: randomized and directed checks of csa_resolver (N=7, W=4)
// against a plain-arithmetic reference model. Follows whichever build of
// the design is selected by CSA_RESOLVER_REDUCE_EN.
module tb_csa_resolver;
    localparam int N = 7;
    localparam int W = 4;
    localparam int K = 2;
`ifdef CSA_RESOLVER_REDUCE_EN
    localparam bit REDUCE = 1'b1;
`else
    localparam bit REDUCE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rstn;
    logic         start;
    logic [N:0]   p;
    logic [N:0]   q;
    logic [N-1:0] n;
    logic         busy;
    logic         done;
    logic [N:0]   r;
    logic         err;

    int errors = 0;
    int checks = 0;

    csa_resolver #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .p     (p),
        .q     (q),
        .n     (n),
        .busy  (busy),
        .done  (done),
        .r     (r),
        .err   (err)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Reference: sum mod 256, then subtract n until it borrows, at most 4 passes.
    function automatic void refModel(input logic [7:0] pv, input logic [7:0] qv,
                                     input logic [6:0] nv, output logic [7:0] er,
                                     output logic ee, output int el);
        int s;
        int passes;
        s      = (int'(pv) + int'(qv)) % 256;
        ee     = 1'b0;
        passes = 0;
        if (REDUCE) begin
            for (int i = 1; i <= 4; i++) begin
                passes = i;
                if (s < int'(nv)) break;
                s = s - int'(nv);
                if (i == 4) ee = 1'b1;
            end
        end
        er = 8'(s);
        el = K + K * passes + 1;
    endfunction

    // Drive one start pulse; returns just after the start edge.
    task automatic applyStimulus(input logic [7:0] pv, input logic [7:0] qv, input logic [6:0] nv);
        @(negedge clk);
        p = pv;
        q = qv;
        n = nv;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Count falling edges until done; optionally fires a stray start while busy.
    task automatic waitResult(input bit intrude, output logic [7:0] oR, output logic oE, output int oLat);
        oLat = -1;
        oR   = 'x;
        oE   = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                oLat = c;
                oR   = r;
                oE   = err;
                break;
            end
            if (intrude && c == 1) begin
                p = 8'hEE; q = 8'h33; n = 7'h05; start = 1'b1;
            end
            if (intrude && c == 2) start = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0; start = 1'b0; p = '0; q = '0; n = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
        checks++; if (r !== 8'h00)   begin errors++; $display("[TB] FAIL reset_r: got %0h expected 0", r); end
        checks++; if (err !== 1'b0)  begin errors++; $display("[TB] FAIL reset_err: got %0b expected 0", err); end
        rstn = 1'b1;
    endtask

    task automatic test_directed;
        logic [7:0] pv[4] = '{8'h80, 8'h10, 8'hFF, 8'h40};
        logic [7:0] qv[4] = '{8'h50, 8'h20, 8'h01, 8'h03};
        logic [6:0] nv[4] = '{7'h65, 7'h65, 7'h65, 7'h00};
        logic [7:0] er, oR;
        logic ee, oE;
        int el, oLat;
        for (int i = 0; i < 4; i++) begin
            refModel(pv[i], qv[i], nv[i], er, ee, el);
            applyStimulus(pv[i], qv[i], nv[i]);
            waitResult(1'b0, oR, oE, oLat);
            checks++; if (oLat !== el) begin errors++; $display("[TB] FAIL directed%0d_latency: got %0d expected %0d", i, oLat, el); end
            checks++; if (oR !== er)   begin errors++; $display("[TB] FAIL directed%0d_r: got %0h expected %0h", i, oR, er); end
            checks++; if (oE !== ee)   begin errors++; $display("[TB] FAIL directed%0d_err: got %0b expected %0b", i, oE, ee); end
            @(negedge clk);
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL directed%0d_pulse: got done=%0b busy=%0b expected 0 0", i, done, busy); end
        end
    endtask

    task automatic test_busy_start;
        logic [7:0] er, oR;
        logic ee, oE;
        int el, oLat;
        refModel(8'h80, 8'h50, 7'h65, er, ee, el);
        applyStimulus(8'h80, 8'h50, 7'h65);
        waitResult(1'b1, oR, oE, oLat);
        checks++; if (oLat !== el) begin errors++; $display("[TB] FAIL busy_start_latency: got %0d expected %0d", oLat, el); end
        checks++; if (oR !== er)   begin errors++; $display("[TB] FAIL busy_start_r: got %0h expected %0h", oR, er); end
        checks++; if (oE !== ee)   begin errors++; $display("[TB] FAIL busy_start_err: got %0b expected %0b", oE, ee); end
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        logic [7:0] er, oR;
        logic ee, oE;
        int el, oLat;
        bit sawDone;
        applyStimulus(8'h80, 8'h50, 7'h65);
        repeat (REDUCE ? 3 : 1) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %0b expected 0", busy); end
        checks++; if (r !== 8'h00)   begin errors++; $display("[TB] FAIL abort_r: got %0h expected 0", r); end
        checks++; if (err !== 1'b0)  begin errors++; $display("[TB] FAIL abort_err: got %0b expected 0", err); end
        sawDone = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) sawDone = 1'b1;
        end
        rstn = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done !== 1'b0) sawDone = 1'b1;
        end
        checks++; if (sawDone !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_done: got %0b expected 0", sawDone); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("[TB] FAIL abort_idle: got %0b expected 0", busy); end
        refModel(8'h80, 8'h50, 7'h65, er, ee, el);
        applyStimulus(8'h80, 8'h50, 7'h65);
        waitResult(1'b0, oR, oE, oLat);
        checks++; if (oLat !== el) begin errors++; $display("[TB] FAIL abort_restart_latency: got %0d expected %0d", oLat, el); end
        checks++; if (oR !== er)   begin errors++; $display("[TB] FAIL abort_restart_r: got %0h expected %0h", oR, er); end
        checks++; if (oE !== ee)   begin errors++; $display("[TB] FAIL abort_restart_err: got %0b expected %0b", oE, ee); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [7:0] er, oR;
        logic ee, oE;
        int el, oLat;
        bit seen;
        refModel(8'h80, 8'h50, 7'h65, er, ee, el);
        applyStimulus(8'h10, 8'h20, 7'h65);
        seen = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first_done: got %0b expected 1", seen); end
        p = 8'h80; q = 8'h50; n = 7'h65; start = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle: got %0b expected 0", busy); end
        @(posedge clk);
        #1 start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept: got %0b expected 1", busy); end
        waitResult(1'b0, oR, oE, oLat);
        checks++; if (oLat !== el) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected %0d", oLat, el); end
        checks++; if (oR !== er)   begin errors++; $display("[TB] FAIL b2b_r: got %0h expected %0h", oR, er); end
        checks++; if (oE !== ee)   begin errors++; $display("[TB] FAIL b2b_err: got %0b expected %0b", oE, ee); end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [7:0] pv, qv, er, oR;
        logic [6:0] nv;
        logic ee, oE;
        int el, oLat;
        for (int i = 0; i < 24; i++) begin
            pv = 8'($urandom);
            qv = 8'($urandom);
            if (i % 5 == 0)      nv = 7'h00;
            else if (i % 4 == 0) nv = 7'($urandom_range(1, 8));
            else                 nv = 7'($urandom);
            refModel(pv, qv, nv, er, ee, el);
            applyStimulus(pv, qv, nv);
            waitResult(1'b0, oR, oE, oLat);
            checks++; if (oLat !== el) begin errors++; $display("[TB] FAIL random%0d_latency: got %0d expected %0d (p=%0h q=%0h n=%0h)", i, oLat, el, pv, qv, nv); end
            checks++; if (oR !== er)   begin errors++; $display("[TB] FAIL random%0d_r: got %0h expected %0h (p=%0h q=%0h n=%0h)", i, oR, er, pv, qv, nv); end
            checks++; if (oE !== ee)   begin errors++; $display("[TB] FAIL random%0d_err: got %0b expected %0b (p=%0h q=%0h n=%0h)", i, oE, ee, pv, qv, nv); end
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_directed();
        test_busy_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit in case the design stalls somewhere unexpected.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
